// File: rtl/ifetch_order_monitor.sv
// ifetch_order_monitor
//   In-order request/response scoreboard for the IF-stage <-> i-cache fetch
//   interface. Every fetch request address is queued; every response must
//   come back for the oldest outstanding address. The block only observes,
//   flags errors as sticky bits, latches the first error, and keeps
//   saturating request/response counters.
//
// Ports
//   clock, reset         core clock; asynchronous active-high reset
//   req_valid, req_addr  fetch request issued this cycle and its address
//   rsp_valid, rsp_addr  instruction returned this cycle and its address
//   flush                pipeline redirect, discards all outstanding entries
//   clear_stats          zeroes counters and error state, queue untouched
//   outstanding          number of queued requests
//   full, empty          occupancy == DEPTH / occupancy == 0
//   err_overflow         sticky: request while full with no pop
//   err_mismatch         sticky: response address != oldest request
//   err_spurious         sticky: response with nothing outstanding
//   first_err_code       00 none, 01 overflow, 10 mismatch, 11 spurious
//   first_err_expected   head address at first mismatch, else 0
//   first_err_got        offending address at first error
//   req_count, rsp_count saturating event counters
module ifetch_order_monitor #(
  parameter int ADDRESS_BITS = 20,
  parameter int DEPTH        = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [ADDRESS_BITS-1:0]    req_addr,
  input  logic                       rsp_valid,
  input  logic [ADDRESS_BITS-1:0]    rsp_addr,
  input  logic                       flush,
  input  logic                       clear_stats,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       full,
  output logic                       empty,
  output logic                       err_overflow,
  output logic                       err_mismatch,
  output logic                       err_spurious,
  output logic [1:0]                 first_err_code,
  output logic [ADDRESS_BITS-1:0]    first_err_expected,
  output logic [ADDRESS_BITS-1:0]    first_err_got,
  output logic [CNT_WIDTH-1:0]       req_count,
  output logic [CNT_WIDTH-1:0]       rsp_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_OVERFLOW = 2'b01;
  localparam logic [1:0] CODE_MISMATCH = 2'b10;
  localparam logic [1:0] CODE_SPURIOUS = 2'b11;

  typedef enum logic {NO_ERR, LATCHED} err_state_t;

  logic [ADDRESS_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]           head_ptr, tail_ptr, head_next, tail_next, wr_idx;
  logic [CW-1:0]           count, count_next;
  logic                    wr_en;

  logic rsp_live, pop, spurious, mismatch, overflow, err_evt;

  err_state_t              state, state_next;
  logic                    capture;
  logic [1:0]              cap_code;
  logic [ADDRESS_BITS-1:0] cap_expected, cap_got;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign outstanding = count;

  // Event decode. Flush masks responses entirely; overflow is only possible
  // when the queue is full and nothing leaves it this cycle.
  always_comb begin
    rsp_live = rsp_valid & ~flush;
    pop      = rsp_live & (count != '0);
    spurious = rsp_live & (count == '0);
    mismatch = pop & (rsp_addr != mem[head_ptr]);
    overflow = req_valid & ~flush & (count == CW'(DEPTH)) & ~pop;
    err_evt  = mismatch | spurious | overflow;
  end

  // Queue next-state. On flush the queue restarts at slot 0 and a same-cycle
  // request becomes its only entry. On overflow the head is dropped while
  // the new request overwrites that same slot, so occupancy is unchanged.
  always_comb begin
    head_next  = head_ptr;
    tail_next  = tail_ptr;
    count_next = count;
    wr_en      = 1'b0;
    wr_idx     = tail_ptr;
    if (flush) begin
      head_next = '0;
      if (req_valid) begin
        wr_en      = 1'b1;
        wr_idx     = '0;
        tail_next  = wrap_inc('0);
        count_next = CW'(1);
      end else begin
        tail_next  = '0;
        count_next = '0;
      end
    end else begin
      if (pop || overflow) begin
        head_next = wrap_inc(head_ptr);
      end
      if (req_valid) begin
        wr_en     = 1'b1;
        tail_next = wrap_inc(tail_ptr);
      end
      if (req_valid && !pop && !overflow) begin
        count_next = count + 1'b1;
      end else if (!req_valid && pop) begin
        count_next = count - 1'b1;
      end
    end
  end

  // Queue storage, pointers and registered occupancy flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      head_ptr <= head_next;
      tail_ptr <= tail_next;
      count    <= count_next;
      full     <= (count_next == CW'(DEPTH));
      empty    <= (count_next == '0);
      if (wr_en) begin
        mem[wr_idx] <= req_addr;
      end
    end
  end

  // First-error FSM: state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= NO_ERR;
    end else begin
      state <= state_next;
    end
  end

  // First-error FSM: next state. clear_stats always returns to NO_ERR and
  // discards any error seen in the same cycle.
  always_comb begin
    state_next = state;
    if (clear_stats) begin
      state_next = NO_ERR;
    end else if (state == NO_ERR && err_evt) begin
      state_next = LATCHED;
    end
  end

  // First-error FSM: capture decision with mismatch > spurious > overflow.
  always_comb begin
    capture      = (state == NO_ERR) && err_evt && !clear_stats;
    cap_code     = CODE_NONE;
    cap_expected = '0;
    cap_got      = '0;
    if (mismatch) begin
      cap_code     = CODE_MISMATCH;
      cap_expected = mem[head_ptr];
      cap_got      = rsp_addr;
    end else if (spurious) begin
      cap_code = CODE_SPURIOUS;
      cap_got  = rsp_addr;
    end else if (overflow) begin
      cap_code = CODE_OVERFLOW;
      cap_got  = req_addr;
    end
  end

  // Sticky flags, first-error capture and saturating counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_overflow       <= 1'b0;
      err_mismatch       <= 1'b0;
      err_spurious       <= 1'b0;
      first_err_code     <= CODE_NONE;
      first_err_expected <= '0;
      first_err_got      <= '0;
      req_count          <= '0;
      rsp_count          <= '0;
    end else if (clear_stats) begin
      err_overflow       <= 1'b0;
      err_mismatch       <= 1'b0;
      err_spurious       <= 1'b0;
      first_err_code     <= CODE_NONE;
      first_err_expected <= '0;
      first_err_got      <= '0;
      req_count          <= '0;
      rsp_count          <= '0;
    end else begin
      if (overflow) err_overflow <= 1'b1;
      if (mismatch) err_mismatch <= 1'b1;
      if (spurious) err_spurious <= 1'b1;
      if (capture) begin
        first_err_code     <= cap_code;
        first_err_expected <= cap_expected;
        first_err_got      <= cap_got;
      end
      if (req_valid && (req_count != '1)) begin
        req_count <= req_count + 1'b1;
      end
      if (rsp_live && (rsp_count != '1)) begin
        rsp_count <= rsp_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_order_monitor.sv
// tb_ifetch_order_monitor
//   Directed bench for ifetch_order_monitor. A queue-based reference model
//   is checked against every output on each falling edge, and hand-computed
//   literal values pin the key points of each scenario.
module tb_ifetch_order_monitor;

  localparam int AB    = 20;
  localparam int DEPTH = 4;
  localparam int CNTW  = 32;
  localparam int OW    = $clog2(DEPTH + 1);

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            req_valid = 1'b0;
  logic [AB-1:0]   req_addr = '0;
  logic            rsp_valid = 1'b0;
  logic [AB-1:0]   rsp_addr = '0;
  logic            flush = 1'b0;
  logic            clear_stats = 1'b0;
  logic [OW-1:0]   outstanding;
  logic            full, empty;
  logic            err_overflow, err_mismatch, err_spurious;
  logic [1:0]      first_err_code;
  logic [AB-1:0]   first_err_expected, first_err_got;
  logic [CNTW-1:0] req_count, rsp_count;

  int testsRun    = 0;
  int testsFailed = 0;

  ifetch_order_monitor #(
    .ADDRESS_BITS(AB),
    .DEPTH(DEPTH),
    .CNT_WIDTH(CNTW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid),
    .rsp_addr(rsp_addr),
    .flush(flush),
    .clear_stats(clear_stats),
    .outstanding(outstanding),
    .full(full),
    .empty(empty),
    .err_overflow(err_overflow),
    .err_mismatch(err_mismatch),
    .err_spurious(err_spurious),
    .first_err_code(first_err_code),
    .first_err_expected(first_err_expected),
    .first_err_got(first_err_got),
    .req_count(req_count),
    .rsp_count(rsp_count)
  );

  always #5 clock = ~clock;

  // Reference model state: outstanding requests as a plain FIFO queue.
  logic [AB-1:0]   mq[$];
  bit              mOvf, mMis, mSpu, mLatched;
  logic [1:0]      mCode;
  logic [AB-1:0]   mExp, mGot;
  logic [CNTW-1:0] mReq, mRsp;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Model update from the spec's rules, evaluated on each rising edge.
  always @(posedge clock or posedge reset) begin : model
    bit            popped, eOvf, eMis, eSpu, rspLive;
    logic [AB-1:0] headVal;
    if (reset) begin
      mq.delete();
      {mOvf, mMis, mSpu, mLatched} = '0;
      mCode = 2'b00; mExp = '0; mGot = '0; mReq = '0; mRsp = '0;
    end else begin
      popped = 0; eOvf = 0; eMis = 0; eSpu = 0; headVal = '0;
      rspLive = rsp_valid && !flush;
      if (flush) begin
        mq.delete();
      end else if (rspLive) begin
        if (mq.size() == 0) begin
          eSpu = 1;
        end else begin
          headVal = mq.pop_front();
          popped  = 1;
          if (headVal != rsp_addr) eMis = 1;
        end
      end
      if (req_valid) begin
        if (!flush && mq.size() == DEPTH && !popped) begin
          eOvf = 1;
          void'(mq.pop_front());
        end
        mq.push_back(req_addr);
      end
      if (clear_stats) begin
        {mOvf, mMis, mSpu, mLatched} = '0;
        mCode = 2'b00; mExp = '0; mGot = '0; mReq = '0; mRsp = '0;
      end else begin
        mOvf |= eOvf; mMis |= eMis; mSpu |= eSpu;
        if (!mLatched && (eMis || eSpu || eOvf)) begin
          mLatched = 1;
          if (eMis) begin
            mCode = 2'b10; mExp = headVal; mGot = rsp_addr;
          end else if (eSpu) begin
            mCode = 2'b11; mExp = '0; mGot = rsp_addr;
          end else begin
            mCode = 2'b01; mExp = '0; mGot = req_addr;
          end
        end
        if (req_valid && mReq != '1) mReq++;
        if (rspLive && mRsp != '1) mRsp++;
      end
    end
  end

  // Full-output comparison against the model on every falling edge.
  always @(negedge clock) begin
    checkOutput("outstanding", 32'(outstanding), 32'(mq.size()));
    checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
    checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
    checkOutput("err_overflow", 32'(err_overflow), 32'(mOvf));
    checkOutput("err_mismatch", 32'(err_mismatch), 32'(mMis));
    checkOutput("err_spurious", 32'(err_spurious), 32'(mSpu));
    checkOutput("first_err_code", 32'(first_err_code), 32'(mCode));
    checkOutput("first_err_expected", 32'(first_err_expected), 32'(mExp));
    checkOutput("first_err_got", 32'(first_err_got), 32'(mGot));
    checkOutput("req_count", req_count, mReq);
    checkOutput("rsp_count", rsp_count, mRsp);
  end

  // Drives one cycle of inputs and returns 1 time unit after the edge
  // that samples them, when the registered outputs have settled.
  task automatic applyStimulus(input bit rv, input logic [AB-1:0] ra,
                               input bit sv, input logic [AB-1:0] sa,
                               input bit fl, input bit cs);
    req_valid   = rv;
    req_addr    = ra;
    rsp_valid   = sv;
    rsp_addr    = sa;
    flush       = fl;
    clear_stats = cs;
    @(posedge clock);
    #1;
    req_valid   = 1'b0;
    rsp_valid   = 1'b0;
    flush       = 1'b0;
    clear_stats = 1'b0;
  endtask

  task automatic doReq(input logic [AB-1:0] a);
    applyStimulus(1, a, 0, '0, 0, 0);
  endtask

  task automatic doRsp(input logic [AB-1:0] a);
    applyStimulus(0, '0, 1, a, 0, 0);
  endtask

  task automatic doClear();
    applyStimulus(0, '0, 0, '0, 0, 1);
  endtask

  initial begin
    logic [AB-1:0] seqA [3];
    logic [OW-1:0] occA [6];
    seqA = '{20'h100, 20'h104, 20'h108};
    occA = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0};

    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    checkOutput("reset outstanding", 32'(outstanding), 32'd0);
    checkOutput("reset empty", 32'(empty), 32'd1);
    checkOutput("reset full", 32'(full), 32'd0);
    checkOutput("reset code", 32'(first_err_code), 32'd0);

    // In-order traffic: three requests then matching responses.
    for (int i = 0; i < 3; i++) begin
      doReq(seqA[i]);
      checkOutput("inorder occ", 32'(outstanding), 32'(occA[i]));
    end
    for (int i = 0; i < 3; i++) begin
      doRsp(seqA[i]);
      checkOutput("inorder occ", 32'(outstanding), 32'(occA[i+3]));
    end
    checkOutput("inorder mismatch", 32'(err_mismatch), 32'd0);
    checkOutput("inorder req_count", req_count, 32'd3);
    checkOutput("inorder rsp_count", rsp_count, 32'd3);

    // Out-of-order response raises a mismatch.
    doReq(20'h200);
    doReq(20'h204);
    doRsp(20'h204);
    checkOutput("mismatch flag", 32'(err_mismatch), 32'd1);
    checkOutput("mismatch code", 32'(first_err_code), 32'd2);
    checkOutput("mismatch expected", 32'(first_err_expected), 32'h200);
    checkOutput("mismatch got", 32'(first_err_got), 32'h204);
    checkOutput("mismatch occ", 32'(outstanding), 32'd1);
    doRsp(20'h204);
    doClear();

    // Overflow drops the oldest entry.
    for (int i = 0; i < 4; i++) doReq(AB'(4 * i));
    checkOutput("fill full", 32'(full), 32'd1);
    doReq(20'h10);
    checkOutput("overflow flag", 32'(err_overflow), 32'd1);
    checkOutput("overflow full", 32'(full), 32'd1);
    checkOutput("overflow code", 32'(first_err_code), 32'd1);
    checkOutput("overflow got", 32'(first_err_got), 32'h10);
    for (int i = 1; i <= 4; i++) doRsp(AB'(4 * i));
    checkOutput("overflow drain mismatch", 32'(err_mismatch), 32'd0);
    checkOutput("overflow drain empty", 32'(empty), 32'd1);
    doClear();

    // Full queue with simultaneous push and matching pop.
    for (int i = 0; i < 4; i++) doReq(AB'(32'h40 + 4 * i));
    applyStimulus(1, 20'h20, 1, 20'h40, 0, 0);
    checkOutput("pushpop overflow", 32'(err_overflow), 32'd0);
    checkOutput("pushpop occ", 32'(outstanding), 32'd4);
    doRsp(20'h44); doRsp(20'h48); doRsp(20'h4C); doRsp(20'h20);
    checkOutput("pushpop drain mismatch", 32'(err_mismatch), 32'd0);

    // Spurious response, then clear_stats.
    doRsp(20'h55);
    checkOutput("spurious flag", 32'(err_spurious), 32'd1);
    checkOutput("spurious code", 32'(first_err_code), 32'd3);
    checkOutput("spurious got", 32'(first_err_got), 32'h55);
    checkOutput("spurious occ", 32'(outstanding), 32'd0);
    doClear();
    checkOutput("clear spurious", 32'(err_spurious), 32'd0);
    checkOutput("clear code", 32'(first_err_code), 32'd0);
    checkOutput("clear req_count", req_count, 32'd0);
    checkOutput("clear rsp_count", rsp_count, 32'd0);

    // clear_stats wins over a same-cycle spurious response.
    applyStimulus(0, '0, 1, 20'h66, 0, 1);
    checkOutput("clearwins spurious", 32'(err_spurious), 32'd0);
    checkOutput("clearwins rsp_count", rsp_count, 32'd0);

    // Flush with simultaneous request and response.
    doReq(20'h500); doReq(20'h504); doReq(20'h508);
    applyStimulus(1, 20'h300, 1, 20'h999, 1, 0);
    checkOutput("flush occ", 32'(outstanding), 32'd1);
    checkOutput("flush mismatch", 32'(err_mismatch), 32'd0);
    checkOutput("flush spurious", 32'(err_spurious), 32'd0);
    checkOutput("flush rsp_count", rsp_count, 32'd0);
    checkOutput("flush req_count", req_count, 32'd4);
    doRsp(20'h300);
    checkOutput("postflush mismatch", 32'(err_mismatch), 32'd0);
    checkOutput("postflush empty", 32'(empty), 32'd1);
    checkOutput("postflush rsp_count", rsp_count, 32'd1);

    // Asynchronous reset between clock edges.
    doReq(20'h700); doReq(20'h704);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset occ", 32'(outstanding), 32'd0);
    checkOutput("async reset empty", 32'(empty), 32'd1);
    checkOutput("async reset req_count", req_count, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    doReq(20'h710);
    checkOutput("after reset occ", 32'(outstanding), 32'd1);
    doRsp(20'h710);
    checkOutput("after reset mismatch", 32'(err_mismatch), 32'd0);

    @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
